// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// dependency-vector bit positions and the sequential PC-source code.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL2   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int DEP_RS_EXE = 0;
  localparam int DEP_RS_MEM = 1;
  localparam int DEP_RT_EXE = 2;
  localparam int DEP_RT_MEM = 3;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;

  // {from MEM, from EXE}: the younger EXE producer shadows MEM; an EXE load has no data yet.
  function automatic logic [1:0] fwd_sel(input logic m_exe, input logic m_mem, input logic exe_sld);
    return {m_mem & ~m_exe, m_exe & ~exe_sld};
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one pipeline stage's destination.
module hazard_match (
  input  logic [4:0] i_src,
  input  logic       i_use,
  input  logic [4:0] i_stage_rn,
  input  logic       i_stage_wreg,
  output logic       o_match
);

  // r0 is hardwired to zero, so it never creates a dependency.
  assign o_match = i_use & (i_src != 5'd0) & i_stage_wreg & (i_stage_rn == i_src);

endmodule

// File: rtl/hazard_controller.sv
// Interlock and forwarding-select controller for the 5-stage pipeline.
// Shadows EXE/MEM destinations, drives stall/bubble/flush/freeze and counts stalls.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_wreg,
  input  logic             id_sld,
  input  logic             id_branch,
  input  logic [1:0]       pcsource,
  input  logic             mem_ready,
  output logic [3:0]       depen,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_ifid,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           r_state;
  logic [4:0]       r_exe_rn;
  logic             r_exe_wreg;
  logic             r_exe_sld;
  logic [4:0]       r_mem_rn;
  logic             r_mem_wreg;
  logic             r_mem_sld;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_rs_exe;
  logic       w_rs_mem;
  logic       w_rt_exe;
  logic       w_rt_mem;
  logic       w_exe_hit;
  logic       w_load_use;
  logic       w_br_exe;
  logic       w_br_load;
  logic [1:0] w_rs_sel;
  logic [1:0] w_rt_sel;
  logic       w_wpcir;
  logic       w_bubble;
  logic       w_flush;
  logic       w_freeze;
  logic [3:0] w_depen;

  hazard_match u_rs_exe (.i_src(id_rs), .i_use(id_use_rs), .i_stage_rn(r_exe_rn),
                         .i_stage_wreg(r_exe_wreg), .o_match(w_rs_exe));
  hazard_match u_rs_mem (.i_src(id_rs), .i_use(id_use_rs), .i_stage_rn(r_mem_rn),
                         .i_stage_wreg(r_mem_wreg), .o_match(w_rs_mem));
  hazard_match u_rt_exe (.i_src(id_rt), .i_use(id_use_rt), .i_stage_rn(r_exe_rn),
                         .i_stage_wreg(r_exe_wreg), .o_match(w_rt_exe));
  hazard_match u_rt_mem (.i_src(id_rt), .i_use(id_use_rt), .i_stage_rn(r_mem_rn),
                         .i_stage_wreg(r_mem_wreg), .o_match(w_rt_mem));

  assign w_exe_hit  = w_rs_exe | w_rt_exe;
  assign w_load_use = w_exe_hit & r_exe_sld;
  assign w_br_exe   = id_branch & w_exe_hit & ~r_exe_sld;
  assign w_br_load  = id_branch & w_exe_hit & r_exe_sld;
  assign w_rs_sel   = fwd_sel(w_rs_exe, w_rs_mem, r_exe_sld);
  assign w_rt_sel   = fwd_sel(w_rt_exe, w_rt_mem, r_exe_sld);

  // Memory wait outranks any stall, which outranks a redirect flush.
  always_comb begin
    w_wpcir  = 1'b1;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_freeze = 1'b0;
    if (!mem_ready) begin
      w_freeze = 1'b1;
      w_wpcir  = 1'b0;
    end else if ((r_state == ST_STALL2) || w_load_use || w_br_exe) begin
      w_wpcir  = 1'b0;
      w_bubble = 1'b1;
    end else begin
      w_flush  = (pcsource != PCSRC_SEQ);
    end
  end

  // Forwarding selects are meaningless for a bubbled instruction.
  always_comb begin
    w_depen = 4'b0000;
    if (!w_bubble) begin
      w_depen[DEP_RS_EXE] = w_rs_sel[0];
      w_depen[DEP_RS_MEM] = w_rs_sel[1];
      w_depen[DEP_RT_EXE] = w_rt_sel[0];
      w_depen[DEP_RT_MEM] = w_rt_sel[1];
    end else begin
      w_depen = 4'b0000;
    end
  end

  // Sequencing: extra stall for branch-on-load, wait state for slow memory.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (!mem_ready)     r_state <= ST_MEM_WAIT;
          else if (w_br_load) r_state <= ST_STALL2;
          else                r_state <= ST_RUN;
        end
        ST_STALL2: begin
          if (!mem_ready) r_state <= ST_MEM_WAIT;
          else            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Shadow copies of the EXE and MEM destination fields.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_exe_rn   <= 5'd0;
      r_exe_wreg <= 1'b0;
      r_exe_sld  <= 1'b0;
      r_mem_rn   <= 5'd0;
      r_mem_wreg <= 1'b0;
      r_mem_sld  <= 1'b0;
    end else if (!w_freeze) begin
      r_mem_rn   <= r_exe_rn;
      r_mem_wreg <= r_exe_wreg;
      r_mem_sld  <= r_exe_sld;
      if (w_bubble) begin
        r_exe_rn   <= 5'd0;
        r_exe_wreg <= 1'b0;
        r_exe_sld  <= 1'b0;
      end else begin
        r_exe_rn   <= id_rd;
        r_exe_wreg <= id_wreg;
        r_exe_sld  <= id_sld;
      end
    end else begin
      r_mem_rn   <= r_mem_rn;
      r_exe_rn   <= r_exe_rn;
    end
  end

  // Saturating count of cycles in which the front end is held.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (!w_wpcir && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign depen      = w_depen;
  assign wpcir      = w_wpcir;
  assign bubble     = w_bubble;
  assign flush_ifid = w_flush;
  assign freeze     = w_freeze;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations,
// then random instruction streams checked against a pipeline-slot model.
module tb_hazard_controller;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clrn;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_use_rs, id_use_rt, id_wreg, id_sld, id_branch;
  logic [1:0]       pcsource;
  logic             mem_ready;
  logic [3:0]       depen;
  logic             wpcir, bubble, flush_ifid, freeze;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_wreg(id_wreg), .id_sld(id_sld), .id_branch(id_branch),
    .pcsource(pcsource), .mem_ready(mem_ready), .depen(depen),
    .wpcir(wpcir), .bubble(bubble), .flush_ifid(flush_ifid),
    .freeze(freeze), .stall_cnt(stall_cnt)
  );

  // Model: the instruction occupying each of EXE and MEM.
  typedef struct {
    logic [4:0] rn;
    bit         wreg;
    bit         sld;
  } slot_t;

  slot_t m_exe, m_mem;
  int    m_extra;
  int    m_cnt;
  bit    e_wpcir, e_bubble, e_flush, e_freeze;
  logic [3:0] e_depen;
  int    e_next_extra;
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic bit writes(slot_t s, bit use_bit, logic [4:0] r);
    return use_bit && (r != 5'd0) && s.wreg && (s.rn == r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_exe   = '{rn: 5'd0, wreg: 1'b0, sld: 1'b0};
    m_mem   = '{rn: 5'd0, wreg: 1'b0, sld: 1'b0};
    m_extra = 0;
    m_cnt   = 0;
  endtask

  task automatic model_eval();
    bit xrs, xrt, mrs, mrt, exe_hit;
    xrs = writes(m_exe, id_use_rs, id_rs);
    xrt = writes(m_exe, id_use_rt, id_rt);
    mrs = writes(m_mem, id_use_rs, id_rs);
    mrt = writes(m_mem, id_use_rt, id_rt);
    exe_hit = xrs || xrt;
    e_freeze = 0; e_flush = 0; e_next_extra = 0; e_wpcir = 1; e_bubble = 0;
    if (!mem_ready) begin
      e_freeze = 1; e_wpcir = 0;
    end else if (m_extra > 0 || (exe_hit && m_exe.sld) || (id_branch && exe_hit)) begin
      e_wpcir = 0; e_bubble = 1;
      if (m_extra == 0 && id_branch && exe_hit && m_exe.sld) e_next_extra = 1;
    end else begin
      e_flush = (pcsource != 2'b00);
    end
    e_depen = 4'b0000;
    if (!e_bubble) begin
      e_depen[0] = xrs && !m_exe.sld;
      e_depen[1] = !xrs && mrs;
      e_depen[2] = xrt && !m_exe.sld;
      e_depen[3] = !xrt && mrt;
    end
  endtask

  task automatic cc();
    @(negedge clk);
    model_eval();
    check("depen", depen, e_depen);
    check("wpcir", wpcir, e_wpcir);
    check("bubble", bubble, e_bubble);
    check("flush_ifid", flush_ifid, e_flush);
    check("freeze", freeze, e_freeze);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!e_freeze) begin
      m_mem = m_exe;
      if (e_bubble) m_exe = '{rn: 5'd0, wreg: 1'b0, sld: 1'b0};
      else          m_exe = '{rn: id_rd, wreg: id_wreg, sld: id_sld};
    end
    m_extra = e_next_extra;
    if (!e_wpcir && m_cnt < CNT_MAX) m_cnt++;
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                        input logic [4:0] rd, input bit wreg, input bit sld, input bit br);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_wreg = wreg; id_sld = sld; id_branch = br;
  endtask

  initial begin
    clrn = 1'b0; pcsource = 2'b00; mem_ready = 1'b1;
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check("rst_depen", depen, 4'b0000);
    check("rst_wpcir", wpcir, 1);
    check("rst_bubble", bubble, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_freeze", freeze, 0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    clrn = 1'b1;

    // add r3 then reader of r3 twice: EXE then MEM forwarding
    set_id(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); cc(); adv();
    set_id(5'd3, 5'd0, 1, 0, 5'd4, 1, 0, 0); cc();
    check("s1_depen_exe", depen, 4'b0001); check("s1_wpcir", wpcir, 1); adv();
    set_id(5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 0); cc();
    check("s1_depen_mem", depen, 4'b0010); adv();

    // lw r5 then add using rt=5: one load-use stall
    set_id(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0); cc(); adv();
    set_id(5'd0, 5'd5, 0, 1, 5'd6, 1, 0, 0); cc();
    check("s2_wpcir", wpcir, 0); check("s2_bubble", bubble, 1); check("s2_depen", depen, 4'b0000); adv();
    cc();
    check("s2_cnt", stall_cnt, 1); check("s2_depen_mem", depen, 4'b1000); check("s2_wpcir_go", wpcir, 1); adv();

    // lw r7 then beq rs=7 with a pending redirect: two stalls, then flush
    set_id(5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0); cc(); adv();
    set_id(5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 1); pcsource = 2'b01; cc();
    check("s3_wpcir1", wpcir, 0); check("s3_flush1", flush_ifid, 0); adv();
    cc();
    check("s3_wpcir2", wpcir, 0); check("s3_flush2", flush_ifid, 0); check("s3_bubble2", bubble, 1); adv();
    cc();
    check("s3_wpcir3", wpcir, 1); check("s3_flush3", flush_ifid, 1); check("s3_cnt", stall_cnt, 3); adv();
    pcsource = 2'b00; set_id(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); cc();
    check("s3_flush4", flush_ifid, 0); adv();

    // load into r0 then branch reading r0: no dependency
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0); cc(); adv();
    set_id(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1); cc();
    check("s4_depen", depen, 4'b0000); check("s4_wpcir", wpcir, 1); adv();

    // memory not ready for three cycles with a pending EXE dependency
    set_id(5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0); cc(); adv();
    set_id(5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cc();
      check("s5_freeze", freeze, 1); check("s5_wpcir", wpcir, 0); check("s5_bubble", bubble, 0); adv();
    end
    mem_ready = 1'b1; cc();
    check("s5_depen", depen, 4'b0001); check("s5_freeze_off", freeze, 0);
    check("s5_cnt", stall_cnt, 6); adv();

    // reset asserted while in the second branch-on-load stall
    set_id(5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0); cc(); adv();
    set_id(5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 1); cc(); adv();
    #2; clrn = 1'b0; #1;
    check("s6_wpcir", wpcir, 1); check("s6_bubble", bubble, 0);
    check("s6_cnt", stall_cnt, 0); check("s6_depen", depen, 4'b0000);
    model_reset();
    @(posedge clk); #1; clrn = 1'b1;
    cc(); check("s6_run", wpcir, 1); adv();

    // random instruction stream
    for (int n = 0; n < 600; n++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0);
      pcsource  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      mem_ready = ($urandom_range(0, 9) != 0);
      cc(); adv();
    end

    // long memory wait drives the counter into saturation
    mem_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cc(); adv();
    end
    cc();
    check("sat_cnt", stall_cnt, CNT_MAX);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
